// File: rtl/run_seq_gen.sv
// Run-sequence generator: emits runs of equal-pair symbols followed by a break
// symbol, plus the predicted output of a downstream equal-pair run detector.
module run_seq_gen #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_sym,
    input  logic             req_alt,
    output logic [1:0]       w,
    output logic             w_valid,
    output logic             busy,
    output logic             exp_z,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BREAK = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state_r;
    logic [LEN_W-1:0] cnt_r;
    logic             pol_r;
    logic             alt_r;
    logic [2:0]       idx_r;

    logic             accept_s;
    logic             pol_next_s;
    logic [2:0]       idx_next_s;

    // Accept decode and next-cycle polarity / saturating run index
    always_comb begin
        accept_s   = req_valid & req_ready;
        pol_next_s = alt_r ? ~pol_r : pol_r;
        if (idx_r == 3'd7) begin
            idx_next_s = 3'd7;
        end else begin
            idx_next_s = idx_r + 3'd1;
        end
    end

    // State machine; outputs are registered for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= LEN_ZERO;
            pol_r     <= 1'b0;
            alt_r     <= 1'b0;
            idx_r     <= 3'd0;
            w         <= 2'b01;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            exp_z     <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            // Fall back to IDLE outputs; each branch below overrides as needed
            state_r   <= IDLE;
            w         <= 2'b01;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            exp_z     <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            case (state_r)
                IDLE, BREAK: begin
                    if (accept_s) begin
                        alt_r <= req_alt;
                        busy  <= 1'b1;
                        if (req_len != LEN_ZERO) begin
                            state_r   <= RUN;
                            cnt_r     <= req_len;
                            pol_r     <= req_sym;
                            idx_r     <= 3'd1;
                            w         <= {req_sym, req_sym};
                            w_valid   <= 1'b1;
                            req_ready <= 1'b0;
                        end else begin
                            state_r <= BREAK;
                            cnt_r   <= LEN_ZERO;
                            w       <= 2'b10;
                            w_valid <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    busy    <= 1'b1;
                    w_valid <= 1'b1;
                    if (cnt_r == LEN_ONE) begin
                        state_r <= BREAK;
                        cnt_r   <= LEN_ZERO;
                        w       <= 2'b10;
                        done    <= 1'b1;
                    end else begin
                        state_r   <= RUN;
                        cnt_r     <= cnt_r - LEN_ONE;
                        pol_r     <= pol_next_s;
                        idx_r     <= idx_next_s;
                        w         <= {pol_next_s, pol_next_s};
                        exp_z     <= (idx_next_s >= 3'd4);
                        req_ready <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_seq_gen.sv
// Directed self-checking bench for run_seq_gen; outputs are checked 1 time unit
// after each rising edge against hand-computed values.
module tb_run_seq_gen;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_len;
    logic       req_sym;
    logic       req_alt;
    logic [1:0] w;
    logic       w_valid;
    logic       busy;
    logic       exp_z;
    logic       done;

    int checks;
    int errors;

    run_seq_gen #(.LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .req_sym   (req_sym),
        .req_alt   (req_alt),
        .w         (w),
        .w_valid   (w_valid),
        .busy      (busy),
        .exp_z     (exp_z),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {w, w_valid, busy, exp_z, done, req_ready} against expectation
    task automatic chk(input string tag, input logic [1:0] ew, input logic ev,
                       input logic eb, input logic ez, input logic ed, input logic er);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {w, w_valid, busy, exp_z, done, req_ready};
        exp = {ew, ev, eb, ez, ed, er};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed w/v/b/z/d/r=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [3:0] l, input logic s, input logic a);
        req_valid = v;
        req_len   = l;
        req_sym   = s;
        req_alt   = a;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req(1'b1, 4'd5, 1'b1, 1'b0);

        // Reset overrides a simultaneous accept
        tick(); chk("rst_a", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); chk("rst_b", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Hold-polarity run, len=5 sym=1; inputs scrambled while running
        rst = 1'b0;
        tick(); chk("hold_1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b0, 4'd2, 1'b0, 1'b1);
        tick(); chk("hold_2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b1, 4'd0, 1'b0, 1'b1);
        tick(); chk("hold_3", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("hold_4", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        req(1'b0, 4'd2, 1'b0, 1'b1);
        tick(); chk("hold_5", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk("hold_brk", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("hold_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Short run, len=3 sym=0
        req(1'b1, 4'd3, 1'b0, 1'b0);
        tick(); chk("short_1", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b0, 4'd3, 1'b0, 1'b0);
        tick(); chk("short_2", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("short_3", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("short_brk", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("short_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Zero length
        req(1'b1, 4'd0, 1'b1, 1'b0);
        tick(); chk("zero_brk", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        req(1'b0, 4'd0, 1'b0, 1'b0);
        tick(); chk("zero_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: len=2 sym=1, then len=4 sym=0 held valid through the run
        req(1'b1, 4'd2, 1'b1, 1'b0);
        tick(); chk("b2b_a1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b1, 4'd4, 1'b0, 1'b0);
        tick(); chk("b2b_a2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("b2b_brk1", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("b2b_b1", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b0, 4'd9, 1'b1, 1'b1);
        tick(); chk("b2b_b2", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("b2b_b3", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("b2b_b4", 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk("b2b_brk2", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("b2b_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Alternating run, len=4 sym=0 alt=1
        req(1'b1, 4'd4, 1'b0, 1'b1);
        tick(); chk("alt_1", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b0, 4'd4, 1'b0, 1'b0);
        tick(); chk("alt_2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("alt_3", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk("alt_4", 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk("alt_brk", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("alt_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset on RUN cycle 2 of len=6 aborts with no done pulse
        req(1'b1, 4'd6, 1'b1, 1'b0);
        tick(); chk("mrst_1", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        req(1'b0, 4'd6, 1'b1, 1'b0);
        tick(); chk("mrst_2", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); chk("mrst_rst", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick(); chk("mrst_idle1", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); chk("mrst_idle2", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Maximum length, len=15 sym=1: no wrap, exp_z high on cycles 4..15
        req(1'b1, 4'd15, 1'b1, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("max_%0d", i), 2'b11, 1'b1, 1'b1, (i >= 4), 1'b0, 1'b0);
            req(1'b0, 4'd1, 1'b0, 1'b1);
        end
        tick(); chk("max_brk", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk("max_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
